axi_lite_rr_arbiter: RTL and testbench
======================================

# axi_lite_rr_arbiter

Shares one AXI4-Lite slave between NUM_SLV_PORTS AXI4-Lite masters with independent round-robin arbitration on the write and read paths. It sits between the per-master AXI-to-AXI-Lite protocol converters and a single shared AXI-Lite peripheral, for example a register file or a configuration bus. Each direction carries at most one outstanding transaction. The AW and W channels are forwarded simultaneously, for compatibility with Xilinx AXI-Lite slaves.

## Interface
- NUM_SLV_PORTS, 4: number of upstream masters; must be at least 2.
- AXI_ADDR_WIDTH, 32: address width on all ports.
- AXI_DATA_WIDTH, 32: data width on all ports; strobe width is AXI_DATA_WIDTH/8.
- IDX_WIDTH, $clog2(NUM_SLV_PORTS): derived; must not be overridden.

Ports:
- Clk_CI  in  1  clock; all logic is on the rising edge.
- Rst_RI  in  1  reset; asynchronous and active-high.
- Slv_PS[NUM_SLV_PORTS]  AXI_LITE.Slave  array  upstream ports; index 0 has the highest priority after reset.
- Mst_PM  AXI_LITE.Master  —  the shared downstream port.
- WrGnt_DO  out  IDX_WIDTH  index of the current or last write grant.
- RdGnt_DO  out  IDX_WIDTH  index of the current or last read grant.
- WrBusy_SO  out  1  high when the write FSM is not in W_IDLE.
- RdBusy_SO  out  1  high when the read FSM is not in R_IDLE.

## Operation
- The write path and read path are fully independent. Each has its own FSM, grant register and round-robin pointer (WrPtr, RdPtr).
- Round-robin rule:
  - Search starts at the pointer and proceeds upward, wrapping modulo NUM_SLV_PORTS.
  - The first requester found wins.
  - When the transaction completes, the pointer is set to (grant+1) mod NUM_SLV_PORTS.
- Write FSM:
  - W_IDLE: the request vector is the aw_valid bits of all Slv_PS ports. If any bit is set, the winner is registered into WrGnt, the AwDone and WDone flags are cleared, and the FSM goes to W_ADDR.
  - W_ADDR: the granted port's aw_addr, w_data and w_strb are forwarded to Mst_PM.
    - Mst_PM.aw_valid = Slv[g].aw_valid & !AwDone.
    - Mst_PM.w_valid = Slv[g].w_valid & !WDone.
    - Slv[g].aw_ready and Slv[g].w_ready mirror Mst_PM's ready signals under the same gating.
    - Each handshake sets its Done flag.
    - When both channels have fired (in the same cycle or in different cycles), the FSM goes to W_RESP.
  - W_RESP: Slv[g].b_valid = Mst_PM.b_valid, b_resp is passed through, and Mst_PM.b_ready = Slv[g].b_ready. On the B handshake, WrPtr is updated and the FSM goes to W_IDLE.
- Read FSM:
  - R_IDLE: the request vector is the ar_valid bits. The winner is registered into RdGnt and the FSM goes to R_ADDR.
  - R_ADDR: ar_addr, ar_valid and ar_ready are connected between Slv[g] and Mst_PM. On the AR handshake the FSM goes to R_DATA.
  - R_DATA: r_valid, r_data, r_resp and r_ready are connected between Mst_PM and Slv[g]. On the R handshake, RdPtr is updated and the FSM goes to R_IDLE.
- Non-granted ports, and all ports while their path is idle:
  - aw_ready, w_ready, ar_ready, b_valid and r_valid are 0.
  - b_resp, r_resp and r_data are 0.
- Mst_PM address, data and strobe outputs are 0 when not in the forwarding state.
- Responses from Mst_PM are passed through unmodified, including SLVERR and DECERR.

## Timing
- Reset state:
  - Both FSMs idle.
  - WrPtr, RdPtr, WrGnt_DO and RdGnt_DO are 0.
  - WrBusy_SO and RdBusy_SO are 0.
  - All valid and ready outputs on every port are 0.
  - AwDone and WDone are 0.
- Reset asserted mid-transaction aborts it immediately. Neither side is completed; the environment must reset the peripheral as well.
- Arbitration takes one cycle: a request sampled at edge k appears as Mst_PM.aw_valid (or ar_valid) in cycle k+1.
- Minimum write occupancy is 3 cycles (W_IDLE, W_ADDR, W_RESP) when the downstream readies and b_valid are immediate. The minimum read is 3 cycles.
- A new grant on a path is made, at the earliest, in the cycle after the B or R handshake. No back-to-back overlap is allowed.
- A requester that deasserts valid before being granted is simply not selected. This is a protocol violation upstream, but it must not hang the arbiter.
- A write and a read may be granted in the same cycle, to the same or to different ports.
- A write is granted on aw_valid alone; W is allowed to arrive later.
- The grant holds until completion. No timeout and no preemption.

## Test plan
- Single write: port 2 issues aw_addr=0x10 and w_data=0xCAFE with the slave ready immediately. Required:
  - Mst_PM aw and w fire in cycle 1.
  - Port 2 receives b_valid with OKAY.
  - WrGnt_DO=2; WrPtr becomes 3.
- Fairness: all 4 ports hold ar_valid continuously. Required:
  - Grant order is 0,1,2,3,0.
  - No port is granted twice before every other requester has been served.
- Split AW/W: the downstream asserts w_ready at cycle 1 and aw_ready at cycle 4. Required:
  - Mst w_valid drops after cycle 1.
  - aw_valid is held until cycle 4.
  - Exactly one B is routed to the grantee.
- Concurrent paths: port 0 writes while port 3 reads in the same cycle. Required: both complete independently, with each response routed only to its own port.
- Error passthrough: the downstream returns r_resp=2'b10 for port 1. Required: port 1 sees SLVERR and ports 0, 2 and 3 see r_valid=0.
- Async reset in W_RESP: assert Rst_RI between clock edges. Required: all outputs go to 0 immediately, and after release port 0 wins a tie with port 1.

Source files
------------

// File: rtl/axi_lite_rr_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// axi_lite_rr_arbiter
//
// Shares one AXI4-Lite slave between NUM_SLV_PORTS AXI4-Lite masters. The write
// path and the read path are arbitrated independently, each round-robin, each
// with at most one outstanding transaction. AW and W are forwarded together
// while a write is granted, so slaves that expect both channels at once work.
//
// Upstream (slave-side) ports are flattened into packed vectors. Port p
// occupies bit p of the 1-bit signals and slice [p*W +: W] of wider signals.
// Port 0 has the highest priority after reset.
//
// Ports:
//   Clk_CI, Rst_RI        clock (rising edge) / asynchronous active-high reset
//   i_slv_aw_*, i_slv_w_*, o_slv_aw_ready, o_slv_w_ready, o_slv_b_*,
//   i_slv_b_ready         write channels of the upstream masters
//   i_slv_ar_*, o_slv_ar_ready, o_slv_r_*, i_slv_r_ready
//                         read channels of the upstream masters
//   o_mst_* / i_mst_*     the shared downstream AXI-Lite port
//   WrGnt_DO, RdGnt_DO    index of the current or last write/read grant
//   WrBusy_SO, RdBusy_SO  high while the write/read FSM is not idle
// -----------------------------------------------------------------------------
module axi_lite_rr_arbiter #(
  parameter int NUM_SLV_PORTS  = 4,   // must be at least 2
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int IDX_WIDTH      = $clog2(NUM_SLV_PORTS)  // derived, do not override
) (
  input  logic                                      Clk_CI,
  input  logic                                      Rst_RI,
  // upstream write address / data / response
  input  logic [NUM_SLV_PORTS*AXI_ADDR_WIDTH-1:0]   i_slv_aw_addr,
  input  logic [NUM_SLV_PORTS-1:0]                  i_slv_aw_valid,
  output logic [NUM_SLV_PORTS-1:0]                  o_slv_aw_ready,
  input  logic [NUM_SLV_PORTS*AXI_DATA_WIDTH-1:0]   i_slv_w_data,
  input  logic [NUM_SLV_PORTS*AXI_DATA_WIDTH/8-1:0] i_slv_w_strb,
  input  logic [NUM_SLV_PORTS-1:0]                  i_slv_w_valid,
  output logic [NUM_SLV_PORTS-1:0]                  o_slv_w_ready,
  output logic [NUM_SLV_PORTS*2-1:0]                o_slv_b_resp,
  output logic [NUM_SLV_PORTS-1:0]                  o_slv_b_valid,
  input  logic [NUM_SLV_PORTS-1:0]                  i_slv_b_ready,
  // upstream read address / data
  input  logic [NUM_SLV_PORTS*AXI_ADDR_WIDTH-1:0]   i_slv_ar_addr,
  input  logic [NUM_SLV_PORTS-1:0]                  i_slv_ar_valid,
  output logic [NUM_SLV_PORTS-1:0]                  o_slv_ar_ready,
  output logic [NUM_SLV_PORTS*AXI_DATA_WIDTH-1:0]   o_slv_r_data,
  output logic [NUM_SLV_PORTS*2-1:0]                o_slv_r_resp,
  output logic [NUM_SLV_PORTS-1:0]                  o_slv_r_valid,
  input  logic [NUM_SLV_PORTS-1:0]                  i_slv_r_ready,
  // shared downstream port
  output logic [AXI_ADDR_WIDTH-1:0]                 o_mst_aw_addr,
  output logic                                      o_mst_aw_valid,
  input  logic                                      i_mst_aw_ready,
  output logic [AXI_DATA_WIDTH-1:0]                 o_mst_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0]               o_mst_w_strb,
  output logic                                      o_mst_w_valid,
  input  logic                                      i_mst_w_ready,
  input  logic [1:0]                                i_mst_b_resp,
  input  logic                                      i_mst_b_valid,
  output logic                                      o_mst_b_ready,
  output logic [AXI_ADDR_WIDTH-1:0]                 o_mst_ar_addr,
  output logic                                      o_mst_ar_valid,
  input  logic                                      i_mst_ar_ready,
  input  logic [AXI_DATA_WIDTH-1:0]                 i_mst_r_data,
  input  logic [1:0]                                i_mst_r_resp,
  input  logic                                      i_mst_r_valid,
  output logic                                      o_mst_r_ready,
  // status
  output logic [IDX_WIDTH-1:0]                      WrGnt_DO,
  output logic [IDX_WIDTH-1:0]                      RdGnt_DO,
  output logic                                      WrBusy_SO,
  output logic                                      RdBusy_SO
);

  localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

  // First requester at or above ptr, wrapping around.
  function automatic logic [IDX_WIDTH-1:0] rr_pick(
    input logic [NUM_SLV_PORTS-1:0] req,
    input logic [IDX_WIDTH-1:0]     ptr
  );
    logic [IDX_WIDTH-1:0] pick;
    logic                 found;
    int                   k;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SLV_PORTS; i++) begin
      k = (int'(ptr) + i) % NUM_SLV_PORTS;
      if (!found && req[k]) begin
        pick  = IDX_WIDTH'(k);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // (grant + 1) mod NUM_SLV_PORTS, valid for non-power-of-two port counts too.
  function automatic logic [IDX_WIDTH-1:0] rr_next(input logic [IDX_WIDTH-1:0] gnt);
    return (gnt == IDX_WIDTH'(NUM_SLV_PORTS - 1)) ? '0 : gnt + 1'b1;
  endfunction

  wr_state_e            r_wr_state;
  rd_state_e            r_rd_state;
  logic [IDX_WIDTH-1:0] r_wr_gnt, r_wr_ptr;
  logic [IDX_WIDTH-1:0] r_rd_gnt, r_rd_ptr;
  logic                 r_aw_done, r_w_done;
  logic                 r_wr_busy, r_rd_busy;

  // ---------------------------------------------------------------------------
  // Signals of the granted port
  // ---------------------------------------------------------------------------
  logic                      w_sel_aw_valid, w_sel_w_valid, w_sel_b_ready;
  logic                      w_sel_ar_valid, w_sel_r_ready;
  logic [AXI_ADDR_WIDTH-1:0] w_sel_aw_addr, w_sel_ar_addr;
  logic [AXI_DATA_WIDTH-1:0] w_sel_w_data;
  logic [STRB_WIDTH-1:0]     w_sel_w_strb;

  assign w_sel_aw_valid = i_slv_aw_valid[r_wr_gnt];
  assign w_sel_w_valid  = i_slv_w_valid[r_wr_gnt];
  assign w_sel_b_ready  = i_slv_b_ready[r_wr_gnt];
  assign w_sel_ar_valid = i_slv_ar_valid[r_rd_gnt];
  assign w_sel_r_ready  = i_slv_r_ready[r_rd_gnt];
  assign w_sel_aw_addr  = i_slv_aw_addr[int'(r_wr_gnt)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
  assign w_sel_w_data   = i_slv_w_data[int'(r_wr_gnt)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign w_sel_w_strb   = i_slv_w_strb[int'(r_wr_gnt)*STRB_WIDTH +: STRB_WIDTH];
  assign w_sel_ar_addr  = i_slv_ar_addr[int'(r_rd_gnt)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];

  logic w_wr_addr_st, w_wr_resp_st, w_rd_addr_st, w_rd_data_st;
  assign w_wr_addr_st = (r_wr_state == W_ADDR);
  assign w_wr_resp_st = (r_wr_state == W_RESP);
  assign w_rd_addr_st = (r_rd_state == R_ADDR);
  assign w_rd_data_st = (r_rd_state == R_DATA);

  // ---------------------------------------------------------------------------
  // Downstream port. A channel whose handshake already happened is masked so a
  // slow partner channel does not cause a second beat.
  // ---------------------------------------------------------------------------
  assign o_mst_aw_valid = w_wr_addr_st & w_sel_aw_valid & ~r_aw_done;
  assign o_mst_w_valid  = w_wr_addr_st & w_sel_w_valid & ~r_w_done;
  assign o_mst_aw_addr  = w_wr_addr_st ? w_sel_aw_addr : '0;
  assign o_mst_w_data   = w_wr_addr_st ? w_sel_w_data : '0;
  assign o_mst_w_strb   = w_wr_addr_st ? w_sel_w_strb : '0;
  assign o_mst_b_ready  = w_wr_resp_st & w_sel_b_ready;

  assign o_mst_ar_valid = w_rd_addr_st & w_sel_ar_valid;
  assign o_mst_ar_addr  = w_rd_addr_st ? w_sel_ar_addr : '0;
  assign o_mst_r_ready  = w_rd_data_st & w_sel_r_ready;

  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  assign w_aw_hs = o_mst_aw_valid & i_mst_aw_ready;
  assign w_w_hs  = o_mst_w_valid & i_mst_w_ready;
  assign w_b_hs  = o_mst_b_ready & i_mst_b_valid;
  assign w_ar_hs = o_mst_ar_valid & i_mst_ar_ready;
  assign w_r_hs  = o_mst_r_ready & i_mst_r_valid;

  // ---------------------------------------------------------------------------
  // Upstream demux: only the granted port of an active path sees anything.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV_PORTS; gi++) begin : g_port
      logic w_wr_sel, w_rd_sel;
      assign w_wr_sel = (r_wr_gnt == IDX_WIDTH'(gi));
      assign w_rd_sel = (r_rd_gnt == IDX_WIDTH'(gi));

      assign o_slv_aw_ready[gi] = w_wr_sel & w_wr_addr_st & i_mst_aw_ready & ~r_aw_done;
      assign o_slv_w_ready[gi]  = w_wr_sel & w_wr_addr_st & i_mst_w_ready & ~r_w_done;
      assign o_slv_b_valid[gi]  = w_wr_sel & w_wr_resp_st & i_mst_b_valid;
      assign o_slv_b_resp[gi*2 +: 2] = (w_wr_sel & w_wr_resp_st) ? i_mst_b_resp : 2'b00;

      assign o_slv_ar_ready[gi] = w_rd_sel & w_rd_addr_st & i_mst_ar_ready;
      assign o_slv_r_valid[gi]  = w_rd_sel & w_rd_data_st & i_mst_r_valid;
      assign o_slv_r_resp[gi*2 +: 2] = (w_rd_sel & w_rd_data_st) ? i_mst_r_resp : 2'b00;
      assign o_slv_r_data[gi*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] =
        (w_rd_sel & w_rd_data_st) ? i_mst_r_data : '0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  logic [IDX_WIDTH-1:0] w_wr_winner, w_rd_winner;
  assign w_wr_winner = rr_pick(i_slv_aw_valid, r_wr_ptr);
  assign w_rd_winner = rr_pick(i_slv_ar_valid, r_rd_ptr);

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_wr_state <= W_IDLE;
      r_wr_gnt   <= '0;
      r_wr_ptr   <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_wr_busy  <= 1'b0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          // Granted on AW alone; W may follow later.
          if (|i_slv_aw_valid) begin
            r_wr_gnt   <= w_wr_winner;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_wr_busy  <= 1'b1;
            r_wr_state <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) r_wr_state <= W_RESP;
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_wr_ptr   <= rr_next(r_wr_gnt);
            r_wr_busy  <= 1'b0;
            r_wr_state <= W_IDLE;
          end
        end
        default: begin
          r_wr_busy  <= 1'b0;
          r_wr_state <= W_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_rd_state <= R_IDLE;
      r_rd_gnt   <= '0;
      r_rd_ptr   <= '0;
      r_rd_busy  <= 1'b0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (|i_slv_ar_valid) begin
            r_rd_gnt   <= w_rd_winner;
            r_rd_busy  <= 1'b1;
            r_rd_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (w_ar_hs) r_rd_state <= R_DATA;
        end
        R_DATA: begin
          if (w_r_hs) begin
            r_rd_ptr   <= rr_next(r_rd_gnt);
            r_rd_busy  <= 1'b0;
            r_rd_state <= R_IDLE;
          end
        end
        default: begin
          r_rd_busy  <= 1'b0;
          r_rd_state <= R_IDLE;
        end
      endcase
    end
  end

  assign WrGnt_DO  = r_wr_gnt;
  assign RdGnt_DO  = r_rd_gnt;
  assign WrBusy_SO = r_wr_busy;
  assign RdBusy_SO = r_rd_busy;

endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_axi_lite_rr_arbiter
//
// Directed bench for axi_lite_rr_arbiter with 4 ports, 32-bit address/data.
// Inputs change 1 ns after a rising edge, outputs are checked 2 ns after it
// (or mid-cycle around the asynchronous reset).
// -----------------------------------------------------------------------------
module tb_axi_lite_rr_arbiter;
  localparam int N  = 4;
  localparam int A  = 32;
  localparam int D  = 32;
  localparam int S  = D / 8;
  localparam int IW = 2;

  logic             Clk_CI, Rst_RI;
  logic [N*A-1:0]   i_slv_aw_addr, i_slv_ar_addr;
  logic [N-1:0]     i_slv_aw_valid, o_slv_aw_ready;
  logic [N*D-1:0]   i_slv_w_data;
  logic [N*S-1:0]   i_slv_w_strb;
  logic [N-1:0]     i_slv_w_valid, o_slv_w_ready;
  logic [N*2-1:0]   o_slv_b_resp, o_slv_r_resp;
  logic [N-1:0]     o_slv_b_valid, i_slv_b_ready;
  logic [N-1:0]     i_slv_ar_valid, o_slv_ar_ready;
  logic [N*D-1:0]   o_slv_r_data;
  logic [N-1:0]     o_slv_r_valid, i_slv_r_ready;
  logic [A-1:0]     o_mst_aw_addr, o_mst_ar_addr;
  logic             o_mst_aw_valid, i_mst_aw_ready;
  logic [D-1:0]     o_mst_w_data, i_mst_r_data;
  logic [S-1:0]     o_mst_w_strb;
  logic             o_mst_w_valid, i_mst_w_ready;
  logic [1:0]       i_mst_b_resp, i_mst_r_resp;
  logic             i_mst_b_valid, o_mst_b_ready;
  logic             o_mst_ar_valid, i_mst_ar_ready;
  logic             i_mst_r_valid, o_mst_r_ready;
  logic [IW-1:0]    WrGnt_DO, RdGnt_DO;
  logic             WrBusy_SO, RdBusy_SO;

  int n_assert = 0;
  int n_fail   = 0;

  axi_lite_rr_arbiter #(
    .NUM_SLV_PORTS (N),
    .AXI_ADDR_WIDTH(A),
    .AXI_DATA_WIDTH(D)
  ) dut (
    .Clk_CI        (Clk_CI),
    .Rst_RI        (Rst_RI),
    .i_slv_aw_addr (i_slv_aw_addr),
    .i_slv_aw_valid(i_slv_aw_valid),
    .o_slv_aw_ready(o_slv_aw_ready),
    .i_slv_w_data  (i_slv_w_data),
    .i_slv_w_strb  (i_slv_w_strb),
    .i_slv_w_valid (i_slv_w_valid),
    .o_slv_w_ready (o_slv_w_ready),
    .o_slv_b_resp  (o_slv_b_resp),
    .o_slv_b_valid (o_slv_b_valid),
    .i_slv_b_ready (i_slv_b_ready),
    .i_slv_ar_addr (i_slv_ar_addr),
    .i_slv_ar_valid(i_slv_ar_valid),
    .o_slv_ar_ready(o_slv_ar_ready),
    .o_slv_r_data  (o_slv_r_data),
    .o_slv_r_resp  (o_slv_r_resp),
    .o_slv_r_valid (o_slv_r_valid),
    .i_slv_r_ready (i_slv_r_ready),
    .o_mst_aw_addr (o_mst_aw_addr),
    .o_mst_aw_valid(o_mst_aw_valid),
    .i_mst_aw_ready(i_mst_aw_ready),
    .o_mst_w_data  (o_mst_w_data),
    .o_mst_w_strb  (o_mst_w_strb),
    .o_mst_w_valid (o_mst_w_valid),
    .i_mst_w_ready (i_mst_w_ready),
    .i_mst_b_resp  (i_mst_b_resp),
    .i_mst_b_valid (i_mst_b_valid),
    .o_mst_b_ready (o_mst_b_ready),
    .o_mst_ar_addr (o_mst_ar_addr),
    .o_mst_ar_valid(o_mst_ar_valid),
    .i_mst_ar_ready(i_mst_ar_ready),
    .i_mst_r_data  (i_mst_r_data),
    .i_mst_r_resp  (i_mst_r_resp),
    .i_mst_r_valid (i_mst_r_valid),
    .o_mst_r_ready (o_mst_r_ready),
    .WrGnt_DO      (WrGnt_DO),
    .RdGnt_DO      (RdGnt_DO),
    .WrBusy_SO     (WrBusy_SO),
    .RdBusy_SO     (RdBusy_SO)
  );

  initial Clk_CI = 1'b0;
  always #5 Clk_CI = ~Clk_CI;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // advance to 1 ns after the next rising edge
  task automatic cyc();
    @(posedge Clk_CI);
    #1;
  endtask

  initial begin
    Rst_RI = 1'b1;
    i_slv_aw_addr = '0; i_slv_aw_valid = '0; i_slv_w_data = '0; i_slv_w_strb = '0;
    i_slv_w_valid = '0; i_slv_b_ready = '0; i_slv_ar_addr = '0; i_slv_ar_valid = '0;
    i_slv_r_ready = '0;
    i_mst_aw_ready = 1'b0; i_mst_w_ready = 1'b0; i_mst_b_resp = 2'b00; i_mst_b_valid = 1'b0;
    i_mst_ar_ready = 1'b0; i_mst_r_data = '0; i_mst_r_resp = 2'b00; i_mst_r_valid = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) cyc();
    chk("rst_wrgnt", 64'(WrGnt_DO), 64'd0);
    chk("rst_rdgnt", 64'(RdGnt_DO), 64'd0);
    chk("rst_busy", 64'({WrBusy_SO, RdBusy_SO}), 64'd0);
    chk("rst_mst_valid_ready", 64'({o_mst_aw_valid, o_mst_w_valid, o_mst_ar_valid,
                                    o_mst_b_ready, o_mst_r_ready}), 64'd0);
    chk("rst_slv_ready_valid", 64'({o_slv_aw_ready, o_slv_w_ready, o_slv_ar_ready,
                                    o_slv_b_valid, o_slv_r_valid}), 64'd0);
    @(negedge Clk_CI);
    Rst_RI = 1'b0;

    // ---------------- single write from port 2 ----------------
    cyc();                                   // cycle 0, idle
    i_slv_aw_valid[2] = 1'b1; i_slv_aw_addr[2*A +: A] = 32'h10;
    i_slv_w_valid[2]  = 1'b1; i_slv_w_data[2*D +: D]  = 32'hCAFE; i_slv_w_strb[2*S +: S] = 4'hF;
    i_slv_b_ready[2]  = 1'b1;
    i_mst_aw_ready = 1'b1; i_mst_w_ready = 1'b1;
    #1;
    chk("t1_idle_mst_awv", 64'(o_mst_aw_valid), 64'd0);
    chk("t1_idle_slv_awr", 64'(o_slv_aw_ready), 64'd0);
    cyc();                                   // cycle 1, W_ADDR
    #1;
    chk("t1_mst_aw_w_valid", 64'({o_mst_aw_valid, o_mst_w_valid}), 64'b11);
    chk("t1_mst_aw_addr", 64'(o_mst_aw_addr), 64'h10);
    chk("t1_mst_w_data", 64'(o_mst_w_data), 64'hCAFE);
    chk("t1_mst_w_strb", 64'(o_mst_w_strb), 64'hF);
    chk("t1_wrgnt", 64'(WrGnt_DO), 64'd2);
    chk("t1_slv_aw_w_ready", 64'({o_slv_aw_ready, o_slv_w_ready}), 64'h44);
    cyc();                                   // cycle 2, W_RESP
    i_slv_aw_valid[2] = 1'b0; i_slv_w_valid[2] = 1'b0;
    i_mst_b_valid = 1'b1; i_mst_b_resp = 2'b00;
    #1;
    chk("t1_mst_awv_after_hs", 64'(o_mst_aw_valid), 64'd0);
    chk("t1_slv_b_valid", 64'(o_slv_b_valid), 64'b0100);
    chk("t1_slv_b_resp", 64'(o_slv_b_resp), 64'h00);
    chk("t1_mst_b_ready", 64'(o_mst_b_ready), 64'd1);
    cyc();                                   // cycle 3, idle again
    i_mst_b_valid = 1'b0;
    #1;
    chk("t1_done_busy", 64'(WrBusy_SO), 64'd0);
    chk("t1_done_wrgnt", 64'(WrGnt_DO), 64'd2);

    // ---------------- read fairness, all ports requesting ----------------
    i_slv_ar_valid = 4'hF; i_slv_r_ready = 4'hF;
    i_mst_ar_ready = 1'b1; i_mst_r_valid = 1'b1; i_mst_r_data = 32'h1;
    for (int k = 0; k < 5; k++) begin
      cyc();                                 // R_ADDR
      #1;
      chk($sformatf("t2_rdgnt_%0d", k), 64'(RdGnt_DO), 64'(k % 4));
      chk($sformatf("t2_ar_ready_%0d", k), 64'(o_slv_ar_ready), 64'(4'b0001 << (k % 4)));
      cyc();                                 // R_DATA
      #1;
      chk($sformatf("t2_r_valid_%0d", k), 64'(o_slv_r_valid), 64'(4'b0001 << (k % 4)));
      cyc();                                 // R_IDLE
      if (k == 4) begin
        i_slv_ar_valid = '0; i_mst_r_valid = 1'b0;
      end
      #1;
      chk($sformatf("t2_idle_busy_%0d", k), 64'(RdBusy_SO), 64'd0);
    end

    // ---------------- split AW/W; pointer 3 beats port 0 ----------------
    cyc();
    i_mst_aw_ready = 1'b0; i_mst_w_ready = 1'b0;
    i_slv_aw_valid[0] = 1'b1; i_slv_aw_addr[0*A +: A] = 32'h40;
    i_slv_aw_valid[3] = 1'b1; i_slv_aw_addr[3*A +: A] = 32'h44;
    i_slv_w_valid[3]  = 1'b1; i_slv_w_data[3*D +: D]  = 32'h5A5A; i_slv_w_strb[3*S +: S] = 4'hF;
    cyc();                                   // cycle 1
    i_mst_w_ready = 1'b1;
    #1;
    chk("t3_wrgnt_ptr", 64'(WrGnt_DO), 64'd3);
    chk("t3_mst_aw_addr", 64'(o_mst_aw_addr), 64'h44);
    chk("t3_c1_slv_w_ready", 64'(o_slv_w_ready), 64'b1000);
    chk("t3_c1_slv_aw_ready", 64'(o_slv_aw_ready), 64'b0000);
    for (int c = 2; c <= 3; c++) begin
      cyc();                                 // cycles 2, 3: W done, AW waiting
      #1;
      chk($sformatf("t3_c%0d_mst_w_valid", c), 64'(o_mst_w_valid), 64'd0);
      chk($sformatf("t3_c%0d_mst_aw_valid", c), 64'(o_mst_aw_valid), 64'd1);
      chk($sformatf("t3_c%0d_slv_w_ready", c), 64'(o_slv_w_ready), 64'd0);
    end
    cyc();                                   // cycle 4
    i_mst_aw_ready = 1'b1;
    #1;
    chk("t3_c4_slv_aw_ready", 64'(o_slv_aw_ready), 64'b1000);
    cyc();                                   // cycle 5, W_RESP
    i_slv_aw_valid = '0; i_slv_w_valid = '0;
    i_mst_aw_ready = 1'b0; i_mst_w_ready = 1'b0;
    i_mst_b_valid = 1'b1; i_mst_b_resp = 2'b00; i_slv_b_ready[3] = 1'b1;
    #1;
    chk("t3_b_valid", 64'(o_slv_b_valid), 64'b1000);
    chk("t3_resp_mst_awv", 64'(o_mst_aw_valid), 64'd0);
    cyc();                                   // downstream keeps b_valid high
    #1;
    chk("t3_single_b", 64'(o_slv_b_valid), 64'd0);
    chk("t3_busy", 64'(WrBusy_SO), 64'd0);
    i_mst_b_valid = 1'b0;

    // ---------------- concurrent write (port 0) and read (port 3) ----------------
    cyc();
    i_slv_aw_valid[0] = 1'b1; i_slv_aw_addr[0*A +: A] = 32'h20;
    i_slv_w_valid[0]  = 1'b1; i_slv_w_data[0*D +: D]  = 32'h1234; i_slv_w_strb[0*S +: S] = 4'h3;
    i_slv_b_ready[0]  = 1'b1;
    i_slv_ar_valid[3] = 1'b1; i_slv_ar_addr[3*A +: A] = 32'h30;
    i_mst_aw_ready = 1'b1; i_mst_w_ready = 1'b1; i_mst_ar_ready = 1'b1;
    cyc();
    #1;
    chk("t4_wrgnt", 64'(WrGnt_DO), 64'd0);
    chk("t4_rdgnt", 64'(RdGnt_DO), 64'd3);
    chk("t4_mst_aw_addr", 64'(o_mst_aw_addr), 64'h20);
    chk("t4_mst_w_strb", 64'(o_mst_w_strb), 64'h3);
    chk("t4_mst_ar_addr", 64'(o_mst_ar_addr), 64'h30);
    chk("t4_slv_readies", 64'({o_slv_aw_ready, o_slv_ar_ready}), 64'b0001_1000);
    cyc();
    i_slv_aw_valid = '0; i_slv_w_valid = '0; i_slv_ar_valid = '0;
    i_mst_b_valid = 1'b1; i_mst_b_resp = 2'b00;
    i_mst_r_valid = 1'b1; i_mst_r_data = 32'hBEEF; i_mst_r_resp = 2'b00;
    #1;
    chk("t4_b_valid", 64'(o_slv_b_valid), 64'b0001);
    chk("t4_r_valid", 64'(o_slv_r_valid), 64'b1000);
    chk("t4_r_data_p3", 64'(o_slv_r_data[3*D +: D]), 64'hBEEF);
    chk("t4_r_data_p0", 64'(o_slv_r_data[0*D +: D]), 64'h0);
    cyc();
    i_mst_b_valid = 1'b0; i_mst_r_valid = 1'b0;
    #1;
    chk("t4_both_idle", 64'({WrBusy_SO, RdBusy_SO}), 64'd0);

    // ---------------- SLVERR passthrough to port 1 ----------------
    cyc();
    i_slv_ar_valid[1] = 1'b1; i_slv_ar_addr[1*A +: A] = 32'h8;
    cyc();
    #1;
    chk("t5_rdgnt", 64'(RdGnt_DO), 64'd1);
    cyc();
    i_slv_ar_valid = '0;
    i_mst_r_valid = 1'b1; i_mst_r_resp = 2'b10; i_mst_r_data = 32'h55;
    #1;
    chk("t5_r_valid", 64'(o_slv_r_valid), 64'b0010);
    chk("t5_r_resp", 64'(o_slv_r_resp), 64'h08);
    cyc();
    i_mst_r_valid = 1'b0; i_mst_r_resp = 2'b00;

    // ---------------- async reset during W_RESP ----------------
    i_slv_aw_valid[1] = 1'b1; i_slv_w_valid[1] = 1'b1; i_slv_b_ready[1] = 1'b1;
    cyc();                                   // W_ADDR
    #1;
    chk("t6_wrgnt", 64'(WrGnt_DO), 64'd1);
    cyc();                                   // W_RESP
    i_slv_aw_valid = '0; i_slv_w_valid = '0;
    i_mst_b_valid = 1'b1; i_mst_b_resp = 2'b11;
    #1;
    chk("t6_b_resp_decerr", 64'(o_slv_b_resp), 64'h0C);
    #2;
    Rst_RI = 1'b1;                           // between edges
    #1;
    chk("t6_rst_b_valid", 64'(o_slv_b_valid), 64'd0);
    chk("t6_rst_b_resp", 64'(o_slv_b_resp), 64'd0);
    chk("t6_rst_mst_b_ready", 64'(o_mst_b_ready), 64'd0);
    chk("t6_rst_busy_gnt", 64'({WrBusy_SO, WrGnt_DO}), 64'd0);
    cyc();
    i_mst_b_valid = 1'b0;
    i_slv_aw_valid[0] = 1'b1; i_slv_aw_valid[1] = 1'b1;
    #3;
    Rst_RI = 1'b0;
    cyc();
    #1;
    chk("t6_tie_after_reset", 64'(WrGnt_DO), 64'd0);
    chk("t6_tie_aw_ready", 64'(o_slv_aw_ready), 64'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
